// File: rtl/row_fetch.sv
// Fetches one display row of PSX 15-bit pixels from VRAM and writes them,
// expanded to 24-bit colour, into the row buffer.
module row_fetch #(
  parameter int ROW_W   = 640,
  parameter int MAX_OUT = 4
) (
  input  logic        clk_33MHz,
  input  logic        rst_n,
  input  logic        vram_re,
  input  logic [8:0]  vram_y,
  input  logic [9:0]  x_tl,
  output logic        mem_req,
  output logic [18:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  output logic        vram_we,
  output logic [9:0]  vram_x,
  output logic [23:0] vram_out,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  localparam int              CNT_W    = $clog2(ROW_W + 1);
  localparam logic [CNT_W-1:0] OUT_LIM  = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROW_W - 1);
  localparam logic [CNT_W-1:0] ROW_END  = CNT_W'(ROW_W);
  localparam logic [9:0]       LAST_X   = 10'(ROW_W - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  state_e             state_q;
  logic               sync1_q, sync2_q, sync3_q;
  logic [8:0]         row_q;
  logic [9:0]         col_q;
  logic [CNT_W-1:0]   issue_cnt_q, recv_cnt_q;
  logic [CNT_W-1:0]   outstanding;
  logic               vram_we_q, done_q, overrun_q;
  logic [9:0]         vram_x_q;
  logic [23:0]        vram_out_q;
  logic               req_evt, grant, accept, last_wr;
  logic               unused_mask;

  function automatic logic [7:0] expand5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  assign unused_mask = mem_rdata[15];

  assign req_evt     = sync2_q & ~sync3_q;
  assign outstanding = issue_cnt_q - recv_cnt_q;
  // Request depends only on registered state, so it cannot drop while stalled.
  assign mem_req     = (state_q == FETCH) && (outstanding < OUT_LIM);
  assign mem_addr    = {row_q, col_q + 10'(issue_cnt_q)};
  assign grant       = mem_req & mem_gnt;
  assign accept      = (state_q != IDLE) && mem_rvalid && (recv_cnt_q != ROW_END);
  assign last_wr     = vram_we_q && (vram_x_q == LAST_X);

  assign vram_we  = vram_we_q;
  assign vram_x   = vram_x_q;
  assign vram_out = vram_out_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign overrun  = overrun_q;

  always_ff @(posedge clk_33MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      vram_we_q   <= 1'b0;
      vram_x_q    <= '0;
      vram_out_q  <= '0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q   <= vram_re;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      vram_we_q <= accept;
      done_q    <= 1'b0;

      if (accept) begin
        vram_x_q   <= 10'(recv_cnt_q);
        vram_out_q <= {expand5(mem_rdata[14:10]), expand5(mem_rdata[9:5]),
                       expand5(mem_rdata[4:0])};
        recv_cnt_q <= recv_cnt_q + 1'b1;
      end
      if (grant) issue_cnt_q <= issue_cnt_q + 1'b1;
      if (req_evt && state_q != IDLE) overrun_q <= 1'b1;

      case (state_q)
        IDLE: if (req_evt) begin
          row_q       <= vram_y;
          col_q       <= x_tl;
          issue_cnt_q <= '0;
          recv_cnt_q  <= '0;
          state_q     <= FETCH;
        end
        FETCH: if (grant && issue_cnt_q == ROW_LAST) state_q <= DRAIN;
        DRAIN: if (last_wr) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_row_fetch.sv
// Bench for row_fetch: in-order VRAM arbiter model feeding a scoreboard of
// expected row-buffer writes, plus a colour-expansion vector table.
module tb_row_fetch;
  localparam int ROW_W   = 640;
  localparam int MAX_OUT = 4;
  localparam int NV      = 6;

  logic        clk = 1'b0;
  logic        rst_n, vram_re, mem_req, mem_gnt, mem_rvalid;
  logic        vram_we, busy, done, overrun;
  logic [8:0]  vram_y;
  logic [9:0]  x_tl, vram_x;
  logic [18:0] mem_addr;
  logic [15:0] mem_rdata;
  logic [23:0] vram_out;

  always #15 clk = ~clk;

  row_fetch #(.ROW_W(ROW_W), .MAX_OUT(MAX_OUT)) dut (
    .clk_33MHz(clk), .rst_n(rst_n), .vram_re(vram_re), .vram_y(vram_y),
    .x_tl(x_tl), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .vram_we(vram_we),
    .vram_x(vram_x), .vram_out(vram_out), .busy(busy), .done(done),
    .overrun(overrun)
  );

  typedef struct { logic [15:0] rdata; logic [23:0] exp_out; } cvec_t;
  typedef struct { int due; logic [15:0] data; bit stale; } resp_t;
  typedef struct { logic [9:0] x; logic [23:0] out; } exp_t;

  cvec_t       cvec [NV];
  resp_t       resp_q [$];
  exp_t        exp_q [$];
  logic [23:0] wr_log [ROW_W];

  int tests = 0, fails = 0;
  int cyc = 0, lat = 2, g_idx = 0, wr_cnt = 0, done_cnt = 0, outs = 0, max_outs = 0;
  bit gnt_rand = 0, exp_done = 0, stall_prev = 0, same_cycle_seen = 0;
  logic [18:0] addr_prev;
  logic [8:0]  exp_row;
  logic [9:0]  exp_col;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [23:0] model_expand(input logic [15:0] d);
    int r, g, b;
    r = int'(d[4:0]);
    g = int'(d[9:5]);
    b = int'(d[14:10]);
    return {8'(b * 8 + b / 4), 8'(g * 8 + g / 4), 8'(r * 8 + r / 4)};
  endfunction

  function automatic logic [15:0] data_for(input int idx);
    if (idx < NV) return cvec[idx].rdata;
    return 16'($urandom);
  endfunction

  // Arbiter model and write monitor, both evaluated on the falling edge.
  initial begin : arb_mon
    exp_t        e;
    resp_t       r;
    bit          gnt, granted;
    logic [15:0] d;
    forever begin
      @(negedge clk);
      cyc++;
      if (done || exp_done) check("done_pulse", done, exp_done);
      if (done) done_cnt++;
      exp_done = 0;
      if (vram_we) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_we: x=%0d out=%0h, no write expected", vram_x, vram_out);
        end else begin
          e = exp_q.pop_front();
          check("vram_x", vram_x, e.x);
          check("vram_out", vram_out, e.out);
          if (e.x == 10'(ROW_W - 1)) exp_done = 1;
        end
        if (vram_x < ROW_W) wr_log[vram_x] = vram_out;
      end
      if (stall_prev) begin
        check("req_hold", mem_req, 1);
        check("addr_hold", mem_addr, addr_prev);
      end
      gnt        = gnt_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      mem_gnt    = gnt;
      granted    = mem_req && gnt;
      stall_prev = mem_req && !gnt;
      addr_prev  = mem_addr;
      if (granted) begin
        check("mem_addr", mem_addr, {exp_row, 10'((int'(exp_col) + g_idx) % 1024)});
        d = data_for(g_idx);
        resp_q.push_back('{cyc + lat, d, 1'b0});
        exp_q.push_back('{10'(g_idx), model_expand(d)});
        g_idx++;
        outs++;
      end
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
        r = resp_q.pop_front();
        mem_rvalid = 1'b1;
        mem_rdata  = r.data;
        if (!r.stale) begin
          outs--;
          if (granted) same_cycle_seen = 1;
        end
      end
      if (outs > max_outs) max_outs = outs;
    end
  end

  task automatic start_row(input logic [8:0] y, input logic [9:0] x);
    @(negedge clk); #2;
    exp_row = y; exp_col = x;
    g_idx = 0; wr_cnt = 0; done_cnt = 0; max_outs = 0;
    vram_y = y; x_tl = x;
    vram_re = 1'b1;
    repeat (3) @(negedge clk);
    #2 vram_re = 1'b0;
    check("busy_after_req", busy, 1);
  endtask

  task automatic wait_row(input string name);
    int n = 0;
    while (done_cnt == 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    #2;
    check({name, "_done_cnt"}, done_cnt, 1);
    check({name, "_grants"}, g_idx, ROW_W);
    check({name, "_writes"}, wr_cnt, ROW_W);
    check({name, "_sb_empty"}, exp_q.size(), 0);
    check({name, "_busy_low"}, busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 1'b0;
    exp_q.delete();
    foreach (resp_q[i]) resp_q[i].stale = 1'b1;
    outs = 0; exp_done = 0; stall_prev = 0;
    #1;
    check("reset_outputs",
          {mem_req, mem_addr, vram_we, vram_x, vram_out, busy, done, overrun}, '0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin : main
    int n;
    rst_n = 1'b0; vram_re = 1'b0; vram_y = '0; x_tl = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    cvec[0] = '{16'h7FFF, 24'hFFFFFF};
    cvec[1] = '{16'h001F, 24'h0000FF};
    cvec[2] = '{16'h8000, 24'h000000};
    cvec[3] = '{16'h03E0, 24'h00FF00};
    cvec[4] = '{16'h7C00, 24'hFF0000};
    cvec[5] = '{16'h2108, 24'h424242};

    repeat (3) @(negedge clk);
    #1 check("reset_outputs",
             {mem_req, mem_addr, vram_we, vram_x, vram_out, busy, done, overrun}, '0);
    #1 rst_n = 1'b1;

    // Basic row, zero-latency grant, rvalid two cycles later.
    lat = 2; gnt_rand = 0;
    start_row(9'd5, 10'd0);
    wait_row("basic");
    for (int i = 0; i < NV; i++) check("colour_vec", wr_log[i], cvec[i].exp_out);

    // Column wrap from 1023 back to 0.
    start_row(9'd200, 10'd1000);
    wait_row("wrap");

    // Backpressure: random grant stalls, ten-cycle read latency.
    lat = 10; gnt_rand = 1; same_cycle_seen = 0;
    start_row(9'd17, 10'd33);
    wait_row("bp");
    check("max_outstanding_le", max_outs <= MAX_OUT, 1);
    check("max_outstanding_hit", max_outs, MAX_OUT);
    check("same_cycle_gnt_rv", same_cycle_seen, 1);

    // Overrun: second request mid-FETCH.
    lat = 2; gnt_rand = 0;
    start_row(9'd300, 10'd512);
    n = 0;
    while (g_idx < 100 && n < 5000) begin @(negedge clk); n++; end
    #2 vram_re = 1'b1;
    repeat (3) @(negedge clk);
    #2 vram_re = 1'b0;
    repeat (3) @(negedge clk);
    #2 check("overrun_set", overrun, 1);
    wait_row("overrun_row");
    check("overrun_sticky", overrun, 1);

    // Reset mid-row, stale rvalids afterwards, then a clean row.
    lat = 10; gnt_rand = 0;
    start_row(9'd44, 10'd100);
    n = 0;
    while (wr_cnt < 300 && n < 10000) begin @(negedge clk); n++; end
    check("reached_pixel_300", wr_cnt >= 300, 1);
    do_reset();
    n = wr_cnt;
    repeat (20) @(negedge clk);
    #2;
    check("no_stale_writes", wr_cnt, n);
    check("stale_drained", resp_q.size(), 0);
    check("overrun_cleared", overrun, 0);
    lat = 2;
    start_row(9'd7, 10'd5);
    wait_row("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #(30 * 90000);
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
